otter_iter_alu: RTL and testbench

//  Parametrised multi-cycle ALU for the OTTER: RV32I base ops plus RV32M mul/div/rem.

---
 rtl/otter_alu_pkg.sv | 48 ++++
 rtl/otter_alu_base.sv | 38 +++
 rtl/otter_iter_alu.sv | 219 +++++++++++++++++++++
 tb/tb_otter_iter_alu.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_alu_pkg.sv
// Shared types for the OTTER iterative ALU: operation codes, FSM states and M-extension selectors.
package otter_alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000,
    ALU_SLL    = 5'b00001,
    ALU_SLT    = 5'b00010,
    ALU_SLTU   = 5'b00011,
    ALU_XOR    = 5'b00100,
    ALU_SRL    = 5'b00101,
    ALU_OR     = 5'b00110,
    ALU_AND    = 5'b00111,
    ALU_SUB    = 5'b01000,
    ALU_LUI    = 5'b01001,
    ALU_SRA    = 5'b01101,
    ALU_MUL    = 5'b10000,
    ALU_MULH   = 5'b10001,
    ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011,
    ALU_DIV    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110,
    ALU_REMU   = 5'b10111
  } alu_fun_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } alu_state_t;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  // Remainder-returning divide ops all have func3[1] set.
  function automatic logic isRemOp(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

// File: rtl/otter_alu_base.sv
// Combinational RV32I base-op unit; the parent registers its result into ALU_OUT.
module otter_alu_base
  import otter_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      fun_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] out_o
);

  localparam int SHW = $clog2(XLEN);

  alu_fun_t       fun;
  logic [SHW-1:0] shamt;

  always_comb begin
    fun   = alu_fun_t'({1'b0, fun_i});
    shamt = b_i[SHW-1:0];
    out_o = '0;
    case (fun)
      ALU_ADD:  out_o = a_i + b_i;
      ALU_SUB:  out_o = a_i - b_i;
      ALU_SLL:  out_o = a_i << shamt;
      ALU_SLT:  out_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: out_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:  out_o = a_i ^ b_i;
      ALU_SRL:  out_o = a_i >> shamt;
      ALU_SRA:  out_o = $signed(a_i) >>> shamt;
      ALU_OR:   out_o = a_i | b_i;
      ALU_AND:  out_o = a_i & b_i;
      ALU_LUI:  out_o = a_i;
      default:  out_o = '0;
    endcase
  end

endmodule

// File: rtl/otter_iter_alu.sv
// Multi-cycle RV32IM ALU for the OTTER EX stage with valid/ready handshakes on both sides.
// Define OTTER_ALU_DIV_EN to build the restoring divider; otherwise div/rem ops return 0 in one cycle.
module otter_iter_alu
  import otter_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [4:0]      ALU_FUN,
  input  logic [XLEN-1:0] SRC_A,
  input  logic [XLEN-1:0] SRC_B,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] ALU_OUT,
  output logic            BUSY
);

  localparam int              CW        = $clog2(XLEN);
  localparam logic [CW-1:0]   ITER_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_VAL   = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_t      stateQ;
  logic            outValidQ;
  logic            busyQ;
  logic [XLEN-1:0] aluOutQ;
  logic [CW-1:0]   iterQ;

  logic            accept;
  logic            mExt;
  logic [2:0]      mOp;
  logic [XLEN-1:0] baseOut;

  assign IN_READY  = (stateQ == IDLE) || ((stateQ == DONE) && OUT_READY);
  assign accept    = IN_VALID && IN_READY;
  assign mExt      = ALU_FUN[4];
  assign mOp       = ALU_FUN[2:0];
  assign OUT_VALID = outValidQ;
  assign ALU_OUT   = aluOutQ;
  assign BUSY      = busyQ;

  otter_alu_base #(.XLEN(XLEN)) u_base (
    .fun_i (ALU_FUN[3:0]),
    .a_i   (SRC_A),
    .b_i   (SRC_B),
    .out_o (baseOut)
  );

  // Multiplier: shift-add on magnitudes; product upper half accumulates, lower half holds the multiplier.
  logic [XLEN-1:0]   mcandQ;
  logic [2*XLEN-1:0] prodQ;
  logic              mulNegQ;
  logic              mulHiQ;
  logic              mulSignA;
  logic              mulSignB;
  logic [XLEN-1:0]   mulMagA;
  logic [XLEN-1:0]   mulMagB;
  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] prodD;
  logic [2*XLEN-1:0] prodFix;

  assign mulSignA = SRC_A[XLEN-1] && ((mOp == M_MULH) || (mOp == M_MULHSU));
  assign mulSignB = SRC_B[XLEN-1] && (mOp == M_MULH);
  assign mulMagA  = mulSignA ? -SRC_A : SRC_A;
  assign mulMagB  = mulSignB ? -SRC_B : SRC_B;
  assign mulSum   = {1'b0, prodQ[2*XLEN-1:XLEN]} + (prodQ[0] ? {1'b0, mcandQ} : {(XLEN+1){1'b0}});
  assign prodD    = {mulSum, prodQ[XLEN-1:1]};
  assign prodFix  = mulNegQ ? -prodD : prodD;

`ifdef OTTER_ALU_DIV_EN
  // Divider: restoring, one quotient bit per cycle; signs are restored in FIX.
  logic [XLEN-1:0] divisorQ;
  logic [XLEN-1:0] quoQ;
  logic [XLEN-1:0] remQ;
  logic            negQuoQ;
  logic            negRemQ;
  logic            remSelQ;
  logic            divSigned;
  logic            divSignA;
  logic            divSignB;
  logic            divZero;
  logic            divOvf;
  logic [XLEN-1:0] divMagA;
  logic [XLEN-1:0] divMagB;
  logic [XLEN:0]   remShift;
  logic [XLEN:0]   remSub;
  logic            divGeq;
  logic [XLEN-1:0] remD;
  logic [XLEN-1:0] quoD;
  logic [XLEN-1:0] quoFix;
  logic [XLEN-1:0] remFix;

  assign divSigned = !mOp[0];
  assign divSignA  = divSigned && SRC_A[XLEN-1];
  assign divSignB  = divSigned && SRC_B[XLEN-1];
  assign divZero   = (SRC_B == '0);
  assign divOvf    = divSigned && (SRC_A == MIN_VAL) && (SRC_B == '1);
  assign divMagA   = divSignA ? -SRC_A : SRC_A;
  assign divMagB   = divSignB ? -SRC_B : SRC_B;
  assign remShift  = {remQ, quoQ[XLEN-1]};
  assign remSub    = remShift - {1'b0, divisorQ};
  assign divGeq    = (remShift >= {1'b0, divisorQ});
  assign remD      = divGeq ? remSub[XLEN-1:0] : remShift[XLEN-1:0];
  assign quoD      = {quoQ[XLEN-2:0], divGeq};
  assign quoFix    = negQuoQ ? -quoQ : quoQ;
  assign remFix    = negRemQ ? -remQ : remQ;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      stateQ    <= IDLE;
      outValidQ <= 1'b0;
      busyQ     <= 1'b0;
      aluOutQ   <= '0;
      iterQ     <= '0;
      mcandQ    <= '0;
      prodQ     <= '0;
      mulNegQ   <= 1'b0;
      mulHiQ    <= 1'b0;
`ifdef OTTER_ALU_DIV_EN
      divisorQ  <= '0;
      quoQ      <= '0;
      remQ      <= '0;
      negQuoQ   <= 1'b0;
      negRemQ   <= 1'b0;
      remSelQ   <= 1'b0;
`endif
    end else begin
      case (stateQ)
        IDLE, DONE: begin
          if (accept) begin
            iterQ <= '0;
            if (!mExt) begin
              stateQ    <= DONE;
              outValidQ <= 1'b1;
              busyQ     <= 1'b0;
              aluOutQ   <= baseOut;
            end else if (!mOp[2]) begin
              stateQ    <= MUL;
              outValidQ <= 1'b0;
              busyQ     <= 1'b1;
              mcandQ    <= mulMagA;
              prodQ     <= {{XLEN{1'b0}}, mulMagB};
              mulNegQ   <= mulSignA ^ mulSignB;
              mulHiQ    <= (mOp != M_MUL);
            end else begin
`ifdef OTTER_ALU_DIV_EN
              if (divZero) begin
                stateQ    <= DONE;
                outValidQ <= 1'b1;
                busyQ     <= 1'b0;
                aluOutQ   <= isRemOp(mOp) ? SRC_A : '1;
              end else if (divOvf) begin
                stateQ    <= DONE;
                outValidQ <= 1'b1;
                busyQ     <= 1'b0;
                aluOutQ   <= isRemOp(mOp) ? '0 : MIN_VAL;
              end else begin
                stateQ    <= DIV;
                outValidQ <= 1'b0;
                busyQ     <= 1'b1;
                divisorQ  <= divMagB;
                quoQ      <= divMagA;
                remQ      <= '0;
                negQuoQ   <= divSignA ^ divSignB;
                negRemQ   <= divSignA;
                remSelQ   <= isRemOp(mOp);
              end
`else
              stateQ    <= DONE;
              outValidQ <= 1'b1;
              busyQ     <= 1'b0;
              aluOutQ   <= '0;
`endif
            end
          end else if ((stateQ == DONE) && OUT_READY) begin
            stateQ    <= IDLE;
            outValidQ <= 1'b0;
          end
        end
        // Last iteration also applies the sign fix and selects the half of the product.
        MUL: begin
          prodQ <= prodD;
          iterQ <= iterQ + CW'(1);
          if (iterQ == ITER_LAST) begin
            stateQ    <= DONE;
            outValidQ <= 1'b1;
            busyQ     <= 1'b0;
            aluOutQ   <= mulHiQ ? prodFix[2*XLEN-1:XLEN] : prodFix[XLEN-1:0];
          end
        end
`ifdef OTTER_ALU_DIV_EN
        DIV: begin
          quoQ  <= quoD;
          remQ  <= remD;
          iterQ <= iterQ + CW'(1);
          if (iterQ == ITER_LAST) begin
            stateQ <= FIX;
          end
        end
        FIX: begin
          stateQ    <= DONE;
          outValidQ <= 1'b1;
          busyQ     <= 1'b0;
          aluOutQ   <= remSelQ ? remFix : quoFix;
        end
`endif
        default: begin
          stateQ    <= IDLE;
          outValidQ <= 1'b0;
          busyQ     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otter_iter_alu.sv
// Self-checking bench for otter_iter_alu: directed vector table, handshake corner sequences,
// and randomized ops against an arithmetic reference model (tracks OTTER_ALU_DIV_EN).
`timescale 1ns/1ps
module tb_otter_iter_alu;

  localparam int XLEN = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [4:0]  aluFun;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        outValid;
  logic        outReady;
  logic [31:0] aluOut;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [4:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expOut;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  otter_iter_alu #(.XLEN(XLEN)) dut (
    .CLK       (clock),
    .RST       (reset),
    .IN_VALID  (inValid),
    .IN_READY  (inReady),
    .ALU_FUN   (aluFun),
    .SRC_A     (srcA),
    .SRC_B     (srcB),
    .OUT_VALID (outValid),
    .OUT_READY (outReady),
    .ALU_OUT   (aluOut),
    .BUSY      (busy)
  );

  // Reference model: plain 64-bit arithmetic straight from the RV32IM definitions.
  function automatic logic [31:0] refAlu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (!f[4]) begin
      case (f[3:0])
        4'b0000: return a + b;
        4'b1000: return a - b;
        4'b0001: return a << b[4:0];
        4'b0010: return (sa < sb) ? 32'd1 : 32'd0;
        4'b0011: return (a < b) ? 32'd1 : 32'd0;
        4'b0100: return a ^ b;
        4'b0101: return a >> b[4:0];
        4'b1101: return $signed(a) >>> b[4:0];
        4'b0110: return a | b;
        4'b0111: return a & b;
        4'b1001: return a;
        default: return 32'd0;
      endcase
    end
    case (f[2:0])
      3'b000: begin p = sa * sb;             return p[31:0];  end
      3'b001: begin p = sa * sb;             return p[63:32]; end
      3'b010: begin p = sa * longint'(ub);   return p[63:32]; end
      3'b011: begin p = ua * ub;             return p[63:32]; end
`ifdef OTTER_ALU_DIV_EN
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  function automatic int refLat(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[4]) return 1;
    if (!f[2]) return XLEN + 1;
`ifdef OTTER_ALU_DIV_EN
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
`else
    return 1;
`endif
  endfunction

  function automatic vec_t mkVec(input string n, input logic [4:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] e, input int l);
    vec_t v;
    v.name = n; v.fun = f; v.a = a; v.b = b; v.expOut = e; v.expLat = l;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Issues one op from an idle DUT (caller sits just after a rising edge), scrambles the
  // inputs once accepted, waits for the result and lets it drain with outReady high.
  task automatic applyStimulus(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat, output logic stallOk);
    aluFun  = f;
    srcA    = a;
    srcB    = b;
    inValid = 1'b1;
    @(posedge clock); #1;
    inValid = 1'b0;
    aluFun  = 5'($urandom);
    srcA    = $urandom;
    srcB    = $urandom;
    lat     = 1;
    stallOk = 1'b1;
    while (!outValid && lat < 100) begin
      if (!busy || inReady) stallOk = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    res = aluOut;
    @(posedge clock); #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  f;
    logic        ok;
    int          lat;

    reset    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b1;
    aluFun   = '0;
    srcA     = '0;
    srcB     = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("reset outValid", {31'd0, outValid}, 32'd0);
    checkOutput("reset aluOut", aluOut, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset inReady", {31'd0, inReady}, 32'd1);

    vecs.push_back(mkVec("add",    5'b00000, 32'd5,          32'd7,          32'd12,         1));
    vecs.push_back(mkVec("sub",    5'b01000, 32'd5,          32'd7,          32'hFFFF_FFFE,  1));
    vecs.push_back(mkVec("sll",    5'b00001, 32'd1,          32'h0000_0023,  32'd8,          1));
    vecs.push_back(mkVec("slt",    5'b00010, 32'hFFFF_FFFF,  32'd1,          32'd1,          1));
    vecs.push_back(mkVec("sltu",   5'b00011, 32'hFFFF_FFFF,  32'd1,          32'd0,          1));
    vecs.push_back(mkVec("xor",    5'b00100, 32'hF0F0_0000,  32'h0FF0_00FF,  32'hFF00_00FF,  1));
    vecs.push_back(mkVec("srl",    5'b00101, 32'h8000_0000,  32'd31,         32'd1,          1));
    vecs.push_back(mkVec("sra",    5'b01101, 32'h8000_0000,  32'd4,          32'hF800_0000,  1));
    vecs.push_back(mkVec("or",     5'b00110, 32'h0000_F00F,  32'h0F00_0F00,  32'h0F00_FF0F,  1));
    vecs.push_back(mkVec("and",    5'b00111, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0F00_0F00,  1));
    vecs.push_back(mkVec("lui",    5'b01001, 32'h1234_5000,  32'hDEAD_BEEF,  32'h1234_5000,  1));
    vecs.push_back(mkVec("undef",  5'b01010, 32'h1234_5678,  32'h1111_1111,  32'd0,          1));
    vecs.push_back(mkVec("mul",    5'b10000, 32'd5,          32'hFFFF_FFFD,  32'hFFFF_FFF1, 33));
    vecs.push_back(mkVec("mulh",   5'b10001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 33));
    vecs.push_back(mkVec("mulhsu", 5'b10010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 33));
    vecs.push_back(mkVec("mulhu",  5'b11011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33));
`ifdef OTTER_ALU_DIV_EN
    vecs.push_back(mkVec("div",    5'b10100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 34));
    vecs.push_back(mkVec("rem",    5'b10110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 34));
    vecs.push_back(mkVec("divu0",  5'b10101, 32'd9,          32'd0,          32'hFFFF_FFFF,  1));
    vecs.push_back(mkVec("remu0",  5'b10111, 32'd9,          32'd0,          32'd9,          1));
    vecs.push_back(mkVec("divovf", 5'b10100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1));
    vecs.push_back(mkVec("removf", 5'b10110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1));
    vecs.push_back(mkVec("divu",   5'b10101, 32'd100,        32'd7,          32'd14,        34));
    vecs.push_back(mkVec("remu",   5'b10111, 32'd100,        32'd7,          32'd2,         34));
`else
    vecs.push_back(mkVec("div",    5'b10100, 32'hFFFF_FFF9,  32'd2,          32'd0,          1));
    vecs.push_back(mkVec("rem",    5'b10110, 32'hFFFF_FFF9,  32'd2,          32'd0,          1));
    vecs.push_back(mkVec("divu0",  5'b10101, 32'd9,          32'd0,          32'd0,          1));
    vecs.push_back(mkVec("remu",   5'b10111, 32'd100,        32'd7,          32'd0,          1));
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].fun, vecs[i].a, vecs[i].b, res, lat, ok);
      checkOutput(vecs[i].name, res, vecs[i].expOut);
      checkOutput({vecs[i].name, " latency"}, lat, vecs[i].expLat);
      if (vecs[i].expLat > 1) checkOutput({vecs[i].name, " stall"}, {31'd0, ok}, 32'd1);
    end

    // Backpressure: result must hold while outReady is low, then a new op is taken on release.
    outReady = 1'b0;
    aluFun   = 5'b00000;
    srcA     = 32'd20;
    srcB     = 32'd22;
    inValid  = 1'b1;
    @(posedge clock); #1;
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    checkOutput("bp latency", lat, 1);
    held = aluOut;
    ok   = 1'b1;
    repeat (10) begin
      if (!outValid || aluOut !== held || inReady) ok = 1'b0;
      @(posedge clock); #1;
    end
    checkOutput("bp hold", {31'd0, ok}, 32'd1);
    checkOutput("bp value", held, 32'd42);
    aluFun   = 5'b01000;
    srcA     = 32'd10;
    srcB     = 32'd3;
    inValid  = 1'b1;
    outReady = 1'b1;
    #1;
    checkOutput("bp inReady", {31'd0, inReady}, 32'd1);
    @(posedge clock); #1;
    inValid = 1'b0;
    checkOutput("b2b valid", {31'd0, outValid}, 32'd1);
    checkOutput("b2b value", aluOut, 32'd7);
    @(posedge clock); #1;

    // Reset in the middle of a multiply aborts it without producing a result.
    aluFun  = 5'b10000;
    srcA    = 32'd3;
    srcB    = 32'd4;
    inValid = 1'b1;
    @(posedge clock); #1;
    inValid = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("rst inReady", {31'd0, inReady}, 32'd1);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    ok = 1'b1;
    repeat (40) begin
      if (outValid) ok = 1'b0;
      @(posedge clock); #1;
    end
    checkOutput("rst no result", {31'd0, ok}, 32'd1);
    applyStimulus(5'b00000, 32'd1, 32'd1, res, lat, ok);
    checkOutput("rst then add", res, 32'd2);

    // Randomized ops, with divider corner operands injected now and then.
    for (int i = 0; i < 80; i++) begin
      f = 5'($urandom_range(0, 31));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = 32'h8000_0000;
        3: b = 32'(($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1);
        default: ;
      endcase
      applyStimulus(f, a, b, res, lat, ok);
      checkOutput($sformatf("rand%0d fun=%05b a=%08h b=%08h", i, f, a, b), res, refAlu(f, a, b));
      checkOutput($sformatf("rand%0d latency fun=%05b", i, f), lat, refLat(f, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
